// File: rtl/debug_pkg.sv
// Shared types and constants for the debug scan controller and its output register.
// DEBUG_SCAN_CHECKSUM_EN adds the CHECK state used for the per-sweep XOR word.
package debug_pkg;

  localparam int DEBUG_SEL_W = 8;
  localparam int SPIKE_SLOT  = 10;
  localparam logic [7:0] CHECKSUM_IDX = 8'hFF;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t ST_IDLE    = 3'd0;
  localparam scan_state_t ST_SET     = 3'd1;
  localparam scan_state_t ST_SETTLE  = 3'd2;
  localparam scan_state_t ST_CAPTURE = 3'd3;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  localparam scan_state_t ST_CHECK   = 3'd4;
`endif

endpackage

// File: rtl/debug_out_skid.sv
// Single-entry output register: holds data/idx/last stable while valid is high
// and the consumer stalls; a flush drops the entry immediately.
module debug_out_skid
  import debug_pkg::*;
#(
  parameter int DATA_W = DEBUG_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] load_idx,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_idx,
  output logic              out_last
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] idx_d, idx_q;
  logic              last_d, last_q;

  // A load on the transfer cycle keeps valid high for back-to-back words.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      idx_d   = load_idx;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: rtl/debug_scan_controller.sv
// Sweeps the SNN debug mux slots, waits out the mux pipeline and streams samples out.
// Define DEBUG_SCAN_CHECKSUM_EN to append an XOR checksum word to every full sweep.
module debug_scan_controller
  import debug_pkg::*;
#(
  parameter int NUM_MP        = SPIKE_SLOT,
  parameter int DATA_W        = DEBUG_SEL_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              single_mode,
  input  logic [DATA_W-1:0] single_sel,
  input  logic              continuous,
  output logic              cfg_en,
  output logic [DATA_W-1:0] cfg_out,
  input  logic [DATA_W-1:0] debug_select_in,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [DATA_W-1:0] sweep_cnt
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  scan_state_t       state_d, state_q;
  logic [DATA_W-1:0] idx_d, idx_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              single_d, single_q;
  logic [DATA_W-1:0] sweep_cnt_d, sweep_cnt_q;
  logic              cfg_en_d, cfg_en_q;
  logic [DATA_W-1:0] cfg_out_d, cfg_out_q;
  logic              busy_d, busy_q;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] acc_d, acc_q;
`endif

  logic              load_s;
  logic              flush_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] load_idx_s;
  logic              load_last_s;
  logic              xfer_s;
  logic              is_spike_s;
  logic              end_sweep_s;

  assign xfer_s     = out_valid & out_ready;
  assign is_spike_s = (idx_q == DATA_W'(NUM_MP));

  // Next-state logic; abort overrides everything including a completing transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    single_d    = single_q;
    sweep_cnt_d = sweep_cnt_q;
`ifdef DEBUG_SCAN_CHECKSUM_EN
    acc_d       = acc_q;
    load_last_s = single_q;
`else
    load_last_s = single_q | is_spike_s;
`endif
    load_s      = 1'b0;
    flush_s     = 1'b0;
    load_data_s = debug_select_in;
    load_idx_s  = idx_q;
    end_sweep_s = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            single_d = single_mode;
            idx_d    = single_mode ? single_sel : '0;
            state_d  = ST_SET;
`ifdef DEBUG_SCAN_CHECKSUM_EN
            acc_d    = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SET: begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            load_s  = 1'b1;
            state_d = ST_CAPTURE;
`ifdef DEBUG_SCAN_CHECKSUM_EN
            acc_d   = acc_q ^ debug_select_in;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (xfer_s) begin
`ifdef DEBUG_SCAN_CHECKSUM_EN
            if (!single_q && is_spike_s) begin
              load_s      = 1'b1;
              load_data_s = acc_q;
              load_idx_s  = DATA_W'(CHECKSUM_IDX);
              load_last_s = 1'b1;
              state_d     = ST_CHECK;
            end else
`endif
            if (!out_last) begin
              idx_d   = idx_q + DATA_W'(1);
              state_d = ST_SET;
            end else begin
              end_sweep_s = 1'b1;
            end
          end else begin
            state_d = ST_CAPTURE;
          end
        end
`ifdef DEBUG_SCAN_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer_s) begin
            end_sweep_s = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          flush_s = 1'b1;
        end
      endcase

      if (end_sweep_s) begin
        sweep_cnt_d = sweep_cnt_q + DATA_W'(1);
        if (continuous && !single_q) begin
          idx_d   = '0;
          state_d = ST_SET;
`ifdef DEBUG_SCAN_CHECKSUM_EN
          acc_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        sweep_cnt_d = sweep_cnt_q;
      end
    end
  end

  // Config strobe and busy are registered from the next state so they align with SET.
  always_comb begin
    cfg_en_d = (state_d == ST_SET);
    busy_d   = (state_d != ST_IDLE);
    if (state_d == ST_SET) begin
      cfg_out_d = idx_d;
    end else begin
      cfg_out_d = cfg_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      single_q    <= 1'b0;
      sweep_cnt_q <= '0;
      cfg_en_q    <= 1'b0;
      cfg_out_q   <= '0;
      busy_q      <= 1'b0;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      single_q    <= single_d;
      sweep_cnt_q <= sweep_cnt_d;
      cfg_en_q    <= cfg_en_d;
      cfg_out_q   <= cfg_out_d;
      busy_q      <= busy_d;
`ifdef DEBUG_SCAN_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  debug_out_skid #(
    .DATA_W (DATA_W)
  ) u_out_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .flush     (flush_s),
    .load_data (load_data_s),
    .load_idx  (load_idx_s),
    .load_last (load_last_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  assign cfg_en    = cfg_en_q;
  assign cfg_out   = cfg_out_q;
  assign busy      = busy_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_debug_scan_controller.sv
// Scoreboard bench for debug_scan_controller with a two-stage debug mux model
// (config register + output register) returning 8'h10 + selected slot.
module tb_debug_scan_controller;

  localparam int NUM_MP = 10;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } sample_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       single_mode = 1'b0;
  logic [7:0] single_sel = 8'd0;
  logic       continuous = 1'b0;
  logic       out_ready = 1'b1;
  logic       cfg_en;
  logic [7:0] cfg_out;
  logic [7:0] debug_select_in;
  logic [7:0] out_data;
  logic [7:0] out_idx;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic [7:0] sweep_cnt;

  logic [7:0] mux_cfg;
  logic [7:0] mux_out;

  sample_t    sb_q[$];
  logic [7:0] cfg_exp_q[$];
  sample_t    mon_e;
  logic [7:0] mon_c;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cfg_cyc = -100;
  int cfg_cnt = 0;
  int c0 = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  debug_scan_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .single_mode     (single_mode),
    .single_sel      (single_sel),
    .continuous      (continuous),
    .cfg_en          (cfg_en),
    .cfg_out         (cfg_out),
    .debug_select_in (debug_select_in),
    .out_data        (out_data),
    .out_idx         (out_idx),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .busy            (busy),
    .sweep_cnt       (sweep_cnt)
  );

  // Debug mux model: config register then registered output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_cfg <= 8'd0;
      mux_out <= 8'd0;
    end else begin
      if (cfg_en) mux_cfg <= cfg_out;
      mux_out <= 8'h10 + mux_cfg;
    end
  end
  assign debug_select_in = mux_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: config writes, capture latency and handshaked samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_en) begin
        if (cfg_exp_q.size() == 0) begin
          check_eq("cfg_unexpected", 32'd1, 32'd0);
        end else begin
          mon_c = cfg_exp_q.pop_front();
          check_eq("cfg_out", {24'd0, cfg_out}, {24'd0, mon_c});
        end
        cfg_cnt++;
        cfg_cyc = cyc;
      end
      if (out_valid && !prev_valid) check_eq("latency", cyc - cfg_cyc, 32'd3);
      if (out_valid && out_ready && !abort) begin
        if (sb_q.size() == 0) begin
          check_eq("sample_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("out_data", {24'd0, out_data}, {24'd0, mon_e.data});
          check_eq("out_idx", {24'd0, out_idx}, {24'd0, mon_e.idx});
          check_eq("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_sweep();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i <= NUM_MP; i++) begin
      sample_t s;
      s.data = 8'h10 + 8'(i);
      s.idx  = 8'(i);
`ifdef DEBUG_SCAN_CHECKSUM_EN
      s.last = 1'b0;
`else
      s.last = (i == NUM_MP);
`endif
      x = x ^ s.data;
      sb_q.push_back(s);
      cfg_exp_q.push_back(8'(i));
    end
`ifdef DEBUG_SCAN_CHECKSUM_EN
    sb_q.push_back('{data: x, idx: 8'hFF, last: 1'b1});
`endif
  endtask

  task automatic push_single(input logic [7:0] sel);
    sb_q.push_back('{data: 8'h10 + sel, idx: sel, last: 1'b1});
    cfg_exp_q.push_back(sel);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (!busy) return;
      tick(1);
    end
    check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_cfg(input logic [7:0] sel, input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (cfg_en && cfg_out == sel) return;
      tick(1);
    end
    check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (out_valid) return;
      tick(1);
    end
    check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_sweeps(input logic [7:0] n, input string tag);
    for (int k = 0; k < 5000; k++) begin
      if (sweep_cnt == n) return;
      tick(1);
    end
    check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    tick(3);
    check_eq("rst_cfg_en", {31'd0, cfg_en}, 32'd0);
    check_eq("rst_cfg_out", {24'd0, cfg_out}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_out_idx", {24'd0, out_idx}, 32'd0);
    check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sweep_cnt", {24'd0, sweep_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Full sweep with a stray start while busy.
    c0 = cfg_cnt;
    push_sweep();
    pulse_start();
    check_eq("sweep_busy", {31'd0, busy}, 32'd1);
    tick(4);
    pulse_start();
    wait_idle("sweep1");
    check_eq("sweep1_cnt", {24'd0, sweep_cnt}, 32'd1);
    check_eq("sweep1_busy", {31'd0, busy}, 32'd0);
    check_eq("sweep1_cfg_pulses", cfg_cnt - c0, NUM_MP + 1);
    check_eq("sweep1_drained", sb_q.size(), 32'd0);

    // Backpressure on slot 3.
    push_sweep();
    pulse_start();
    wait_cfg(8'd3, "bp_cfg");
    out_ready = 1'b0;
    wait_valid("bp_valid");
    c0 = cfg_cnt;
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_idx", {24'd0, out_idx}, 32'd3);
      check_eq("bp_data", {24'd0, out_data}, 32'h13);
      tick(1);
    end
    check_eq("bp_no_cfg", cfg_cnt - c0, 32'd0);
    out_ready = 1'b1;
    wait_idle("bp");
    check_eq("bp_cnt", {24'd0, sweep_cnt}, 32'd2);
    check_eq("bp_drained", sb_q.size(), 32'd0);

    // Single slot 7; mode inputs change after start to prove they were latched.
    c0 = cfg_cnt;
    single_mode = 1'b1;
    single_sel = 8'd7;
    push_single(8'd7);
    pulse_start();
    single_mode = 1'b0;
    single_sel = 8'd3;
    wait_idle("single7");
    check_eq("single7_cfg_pulses", cfg_cnt - c0, 32'd1);
    check_eq("single7_cnt", {24'd0, sweep_cnt}, 32'd3);
    check_eq("single7_drained", sb_q.size(), 32'd0);

    // Single slot beyond the spike slot is written as-is.
    single_mode = 1'b1;
    single_sel = 8'd12;
    push_single(8'd12);
    pulse_start();
    single_mode = 1'b0;
    wait_idle("single12");
    check_eq("single12_cnt", {24'd0, sweep_cnt}, 32'd4);
    check_eq("single12_drained", sb_q.size(), 32'd0);

    // start and abort together in IDLE.
    c0 = cfg_cnt;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check_eq("sa_busy", {31'd0, busy}, 32'd0);
    tick(4);
    check_eq("sa_no_cfg", cfg_cnt - c0, 32'd0);

    // Continuous sweeps, abort while slot 4 of the third sweep is presented.
    continuous = 1'b1;
    push_sweep();
    push_sweep();
    push_sweep();
    pulse_start();
    wait_sweeps(8'd6, "cont");
    wait_cfg(8'd4, "cont_cfg");
    wait_valid("cont_valid");
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_cfg_en", {31'd0, cfg_en}, 32'd0);
    check_eq("abort_cnt", {24'd0, sweep_cnt}, 32'd6);
    continuous = 1'b0;
    sb_q.delete();
    cfg_exp_q.delete();
    tick(3);
    check_eq("abort_stays_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a sweep.
    push_sweep();
    pulse_start();
    wait_cfg(8'd5, "rst_cfg");
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_cfg_en", {31'd0, cfg_en}, 32'd0);
    check_eq("midrst_cnt", {24'd0, sweep_cnt}, 32'd0);
    check_eq("midrst_data", {24'd0, out_data}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    sb_q.delete();
    cfg_exp_q.delete();
    tick(3);
    check_eq("midrst_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
